// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write-to-read bypass, hardwired zero and pending scoreboard
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rd_addr_i          NUM_RD packed read addresses
//   rd_data_o          NUM_RD packed combinational read data
//   rd_busy_o          per read port: addressed register has an outstanding claim
//   wr_en_i            per write port enable
//   wr_addr_i          NUM_WR packed write addresses
//   wr_data_i          NUM_WR packed write data
//   claim_en_i         mark claim_addr_i pending
//   claim_addr_i       register being claimed
//   wr_collision_o     registered: two enabled write ports hit the same address last cycle
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*WIDTH-1:0]  rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data_i,
  input  logic                     claim_en_i,
  input  logic [ADDR_W-1:0]        claim_addr_i,
  output logic                     wr_collision_o
);
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              coll_q, coll_d;
  logic [NUM_WR-1:0] wv;
  logic              cv;

  // Address names a real, writable register (in range and not the hardwired zero)
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !(ZERO_REG != 0 && a == '0);
  endfunction

  // Ascending port order makes the highest-index write win; the claim is applied last so it wins over writes
  always_comb begin
    cv     = claim_en_i && ok(claim_addr_i);
    wv     = '0;
    mem_d  = mem_q;
    pend_d = pend_q;
    coll_d = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      wv[j] = wr_en_i[j] && ok(wr_addr_i[j*ADDR_W +: ADDR_W]);
      if (wv[j]) begin
        mem_d[wr_addr_i[j*ADDR_W +: ADDR_W]]  = wr_data_i[j*WIDTH +: WIDTH];
        pend_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      for (int k = 0; k < j; k++)
        if (wv[j] && wv[k] && wr_addr_i[j*ADDR_W +: ADDR_W] == wr_addr_i[k*ADDR_W +: ADDR_W]) coll_d = 1'b1;
    end
    if (cv) pend_d[claim_addr_i] = 1'b1;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
    logic              hit;
    assign a = rd_addr_i[g*ADDR_W +: ADDR_W];
    always_comb begin
      d   = ok(a) ? mem_q[a] : '0;
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++)
        if (BYPASS != 0 && wv[j] && wr_addr_i[j*ADDR_W +: ADDR_W] == a) begin
          d   = wr_data_i[j*WIDTH +: WIDTH];
          hit = 1'b1;
        end
    end
    // A retiring write hides the pending bit unless a new claim lands on the same register
    assign rd_data_o[g*WIDTH +: WIDTH] = rst_n ? d : '0;
    assign rd_busy_o[g] = rst_n && ok(a) && pend_q[a] && !(hit && !(cv && claim_addr_i == a));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      pend_q <= '0;
      coll_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      coll_q <= coll_d;
    end

  assign wr_collision_o = coll_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomised checks of reg_file_mp against a scoreboard of expected values
module tb_reg_file_mp;
  localparam int W = 32, AW = 5, NR = 2, NW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*W-1:0]  wr_data;
  logic             claim_en, coll;
  logic [AW-1:0]    claim_addr;

  logic [15:0]  s_rd_addr;
  logic [127:0] s_rd_data;
  logic [3:0]   s_rd_busy;
  logic [0:0]   s_wr_en;
  logic [3:0]   s_wr_addr, s_claim_addr, a_t;
  logic [31:0]  s_wr_data;
  logic         s_claim_en, s_coll;

  logic [31:0] m_mem [16];
  logic [15:0] m_pend;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .claim_en_i(claim_en),
    .claim_addr_i(claim_addr), .wr_collision_o(coll)
  );

  reg_file_mp #(.WIDTH(32), .DEPTH(16), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)) dut_sw (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_busy_o(s_rd_busy),
    .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data), .claim_en_i(s_claim_en),
    .claim_addr_i(s_claim_addr), .wr_collision_o(s_coll)
  );

  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1; wr_addr[p*AW +: AW] = AW'(a); wr_data[p*W +: W] = d;
  endtask

  function automatic logic [31:0] rdd(input int p);
    return rd_data[p*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    idle(); rd_addr = '0; set_rd(1, 5);
    s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0; s_claim_en = 1'b0; s_claim_addr = '0; s_rd_addr = '0;
    #3;
    set_wr(0, 5, 32'hDEADBEEF);
    push("rst_rd0", 0); push("rst_rd1_bypass_gated", 0); push("rst_busy", 0); push("rst_coll", 0);
    #1;
    pop_chk(rdd(0)); pop_chk(rdd(1)); pop_chk(32'(rd_busy)); pop_chk(32'(coll));
    #4 idle();
    #4 rst_n = 1'b1;
    tick();
    push("rst_write_dropped", 0); #1; pop_chk(rdd(1));

    set_wr(0, 7, 32'h12345678); set_rd(1, 7); set_rd(0, 8);
    push("byp_same_cycle", 32'h12345678); push("byp_other_port", 0);
    #1; pop_chk(rdd(1)); pop_chk(rdd(0));
    tick(); idle();
    push("byp_stored", 32'h12345678); #1; pop_chk(rdd(1));

    set_wr(0, 3, 32'h1111); set_wr(1, 3, 32'h2222); set_rd(0, 3);
    push("prio_bypass", 32'h2222); push("prio_coll_before", 0);
    #1; pop_chk(rdd(0)); pop_chk(32'(coll));
    tick(); idle();
    push("prio_stored", 32'h2222); push("prio_coll", 1);
    #1; pop_chk(rdd(0)); pop_chk(32'(coll));
    tick();
    push("prio_coll_clear", 0); #1; pop_chk(32'(coll));

    set_wr(0, 0, 32'hFFFFFFFF); set_wr(1, 0, 32'hFFFFFFFF); claim_en = 1'b1; claim_addr = '0;
    set_rd(0, 0); set_rd(1, 0);
    push("zero_rd0", 0); push("zero_rd1", 0); push("zero_busy", 0);
    #1; pop_chk(rdd(0)); pop_chk(rdd(1)); pop_chk(32'(rd_busy));
    tick(); idle();
    push("zero_rd0_after", 0); push("zero_busy_after", 0); push("zero_coll", 0);
    #1; pop_chk(rdd(0)); pop_chk(32'(rd_busy)); pop_chk(32'(coll));

    claim_en = 1'b1; claim_addr = 5'd9; set_rd(0, 9); set_rd(1, 3);
    push("sb_busy_claim_cycle", 0); #1; pop_chk(32'(rd_busy[0]));
    tick(); idle();
    push("sb_unclaimed_r3", 0); #1; pop_chk(32'(rd_busy[1]));
    for (int c = 0; c < 4; c++) begin
      push($sformatf("sb_busy_hold%0d", c), 1); #1; pop_chk(32'(rd_busy[0]));
      tick();
    end
    set_wr(1, 9, 32'hA5);
    push("sb_write_busy", 0); push("sb_write_data", 32'hA5);
    #1; pop_chk(32'(rd_busy[0])); pop_chk(rdd(0));
    tick(); idle();
    push("sb_after_busy", 0); push("sb_after_data", 32'hA5);
    #1; pop_chk(32'(rd_busy[0])); pop_chk(rdd(0));
    claim_en = 1'b1; claim_addr = 5'd9;
    tick();
    set_wr(0, 9, 32'hB6);
    push("sb_cw_busy", 1); push("sb_cw_data", 32'hB6);
    #1; pop_chk(32'(rd_busy[0])); pop_chk(rdd(0));
    tick(); idle();
    push("sb_cw_busy_after", 1); push("sb_cw_data_after", 32'hB6);
    #1; pop_chk(32'(rd_busy[0])); pop_chk(rdd(0));

    set_wr(0, 5, 32'hDEADBEEF);
    tick(); idle(); set_rd(0, 5); set_rd(1, 9);
    push("rmid_r5_before", 32'hDEADBEEF); push("rmid_busy_before", 2);
    #1; pop_chk(rdd(0)); pop_chk(32'(rd_busy));
    #2 rst_n = 1'b0;
    push("rmid_r5", 0); push("rmid_r9", 0); push("rmid_busy", 0);
    #1; pop_chk(rdd(0)); pop_chk(rdd(1)); pop_chk(32'(rd_busy));
    #2 rst_n = 1'b1;
    tick();
    push("rmid_r5_after", 0); push("rmid_busy_after", 0); push("rmid_coll_after", 0);
    #1; pop_chk(rdd(0)); pop_chk(32'(rd_busy)); pop_chk(32'(coll));

    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_pend = '0;
    for (int n = 0; n < 10000; n++) begin
      tick();
      s_wr_en = 1'($urandom_range(0, 1));
      s_wr_addr = 4'($urandom_range(0, 15));
      s_wr_data = $urandom();
      s_claim_en = ($urandom_range(0, 3) == 0);
      s_claim_addr = 4'($urandom_range(0, 15));
      s_rd_addr = 16'($urandom());
      for (int i = 0; i < 4; i++) begin
        a_t = s_rd_addr[i*4 +: 4];
        push($sformatf("sw_data%0d_cyc%0d", i, n), a_t == 0 ? 32'h0 : m_mem[a_t]);
        push($sformatf("sw_busy%0d_cyc%0d", i, n), a_t == 0 ? 32'h0 : 32'(m_pend[a_t]));
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        pop_chk(s_rd_data[i*32 +: 32]);
        pop_chk(32'(s_rd_busy[i]));
      end
      if (s_wr_en[0] && s_wr_addr != 0) begin
        m_mem[s_wr_addr] = s_wr_data;
        m_pend[s_wr_addr] = 1'b0;
      end
      if (s_claim_en && s_claim_addr != 0) m_pend[s_claim_addr] = 1'b1;
    end
    push("sw_coll", 0); #1; pop_chk(32'(s_coll));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
